// File: rtl/radiant_coinc_trigger_if.sv
// Register port of the RADIANT coincidence trigger: single-cycle write/read
// strobes with a word address; read data is registered inside the slave.
interface radiant_coinc_trigger_if;
  // Handshake: reg_wr/reg_rd are one-cycle strobes with no ready; a write
  // lands on the clock edge that samples reg_wr, and reg_rdat updates on the
  // edge that samples reg_rd and holds until the next read.
  logic        reg_wr;
  logic        reg_rd;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdat;
  logic [31:0] reg_rdat;

  modport master (
    output reg_wr, reg_rd, reg_addr, reg_wdat,
    input  reg_rdat
  );

  modport slave (
    input  reg_wr, reg_rd, reg_addr, reg_wdat,
    output reg_rdat
  );
endinterface

// File: rtl/radiant_coinc_trigger.sv
// 24-channel coincidence trigger with soft trigger, trigger counter and a
// CPU inhibit that blocks further triggers until software clears it.
module radiant_coinc_trigger #(
  parameter int               NCHAN         = 24,
  parameter logic [NCHAN-1:0] TRIG_POLARITY = '0
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic [NCHAN-1:0]       trig_i,
  radiant_coinc_trigger_if.slave bus,
  output logic                   trig_o,
  output logic                   inhibit_o
);

  localparam logic [3:0] A_CTRL     = 4'd0;
  localparam logic [3:0] A_IN_MASK  = 4'd1;
  localparam logic [3:0] A_TRIG_CFG = 4'd2;
  localparam logic [3:0] A_TRIG_MSK = 4'd3;
  localparam logic [3:0] A_WINDOW   = 4'd4;
  localparam logic [3:0] A_THRESH   = 4'd5;
  localparam logic [3:0] A_OVERLORD = 4'd6;
  localparam logic [3:0] A_COUNT    = 4'd7;

  logic             ctrl_en;
  logic [NCHAN-1:0] in_mask;
  logic             coinc_en;
  logic [NCHAN-1:0] trig_mask;
  logic [14:0]      win_cfg;
  logic [4:0]       thresh;
  logic             soft_pending;
  logic             inhibit;
  logic [15:0]      trig_count;
  logic [NCHAN-1:0] x_r;
  logic [NCHAN-1:0] x_d;
  logic [6:0]       win_cnt [NCHAN];

  logic [NCHAN-1:0] edge_q;
  logic [NCHAN-1:0] active;
  logic [5:0]       n_active;
  logic [5:0]       n_needed;
  logic [6:0]       win_len;
  logic             coinc;
  logic             fire;
  logic             wr_ovl;
  logic [31:0]      rd_data;
  logic             unused_wdat;

  assign unused_wdat = ^bus.reg_wdat[30:24];

  // Window length never overflows 7 bits: 1 + 3*31 = 94.
  assign win_len = 7'd1 + 7'(win_cfg[4:0]) + 7'(win_cfg[9:5]) + 7'(win_cfg[14:10]);
  assign edge_q  = x_r & ~x_d & in_mask & trig_mask;
  assign n_needed = 6'(thresh) + 6'd1;
  assign wr_ovl   = bus.reg_wr && (bus.reg_addr == A_OVERLORD);

  always_comb begin
    n_active = '0;
    for (int i = 0; i < NCHAN; i++) begin
      active[i] = (win_cnt[i] != 7'd0);
      n_active  = n_active + 6'(active[i]);
    end
  end

  assign coinc = ctrl_en & coinc_en & (n_active >= n_needed);
  // Soft and coincidence requests merge here, so a simultaneous pair yields
  // one pulse and one count.
  assign fire  = (coinc | soft_pending) & ~inhibit;

  always_comb begin
    rd_data = '0;
    case (bus.reg_addr)
      A_CTRL:     rd_data = {31'b0, ctrl_en};
      A_IN_MASK:  rd_data = 32'(in_mask);
      A_TRIG_CFG: rd_data = {coinc_en, 31'b0};
      A_TRIG_MSK: rd_data = 32'(trig_mask);
      A_WINDOW:   rd_data = {17'b0, win_cfg};
      A_THRESH:   rd_data = {27'b0, thresh};
      A_OVERLORD: rd_data = {trig_count, 14'b0, soft_pending, inhibit};
      A_COUNT:    rd_data = {16'b0, trig_count};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ctrl_en      <= 1'b0;
      in_mask      <= '0;
      coinc_en     <= 1'b0;
      trig_mask    <= '0;
      win_cfg      <= '0;
      thresh       <= '0;
      bus.reg_rdat <= '0;
    end else begin
      if (bus.reg_wr) begin
        case (bus.reg_addr)
          A_CTRL:     ctrl_en   <= bus.reg_wdat[0];
          A_IN_MASK:  in_mask   <= bus.reg_wdat[NCHAN-1:0];
          A_TRIG_CFG: coinc_en  <= bus.reg_wdat[31];
          A_TRIG_MSK: trig_mask <= bus.reg_wdat[NCHAN-1:0];
          A_WINDOW:   win_cfg   <= bus.reg_wdat[14:0];
          A_THRESH:   thresh    <= bus.reg_wdat[4:0];
          default:    ;
        endcase
      end
      if (bus.reg_rd) bus.reg_rdat <= rd_data;
    end
  end

  // Overlord: a pending soft trigger lives exactly one cycle, so one raised
  // while inhibited is dropped rather than queued.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      soft_pending <= 1'b0;
      inhibit      <= 1'b0;
      trig_o       <= 1'b0;
      trig_count   <= '0;
    end else begin
      soft_pending <= wr_ovl & bus.reg_wdat[0];
      trig_o       <= fire;
      if (fire) begin
        inhibit    <= 1'b1;
        trig_count <= trig_count + 16'd1;
      end else if (wr_ovl && bus.reg_wdat[1]) begin
        inhibit    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      x_r <= '0;
      x_d <= '0;
      for (int i = 0; i < NCHAN; i++) win_cnt[i] <= '0;
    end else begin
      x_r <= trig_i ^ TRIG_POLARITY;
      x_d <= x_r;
      for (int i = 0; i < NCHAN; i++) begin
        if (fire)           win_cnt[i] <= '0;
        else if (edge_q[i]) win_cnt[i] <= win_len;
        else if (active[i]) win_cnt[i] <= win_cnt[i] - 7'd1;
      end
    end
  end

  assign inhibit_o = inhibit;

endmodule

// File: tb/tb_radiant_coinc_trigger.sv
// Directed bench for radiant_coinc_trigger: overlord sequencing, coincidence
// window boundaries, masking, input polarity and asynchronous reset.
module tb_radiant_coinc_trigger;

  localparam logic [23:0] BASE = 24'h000001;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [23:0] trig_i;
  logic        trig_o;
  logic        inhibit_o;
  int          n_cmp = 0;
  int          n_err = 0;
  int          np;
  int          first;
  logic [31:0] rd;

  radiant_coinc_trigger_if bus ();

  radiant_coinc_trigger #(.NCHAN(24), .TRIG_POLARITY(24'h000001)) u_dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .trig_i    (trig_i),
    .bus       (bus),
    .trig_o    (trig_o),
    .inhibit_o (inhibit_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] addr, input logic [31:0] data);
    bus.reg_wr   = 1'b1;
    bus.reg_addr = addr;
    bus.reg_wdat = data;
    step();
    bus.reg_wr   = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] addr, output logic [31:0] data);
    bus.reg_rd   = 1'b1;
    bus.reg_addr = addr;
    step();
    bus.reg_rd   = 1'b0;
    data = bus.reg_rdat;
  endtask

  // One-clock pulses on channels 0/1/2 at the given steps (-1 = none);
  // channel 0 is inverted, so its pulse drives the pin low.
  task automatic run3(input int t0, input int t1, input int t2, input int len,
                      output int npulse, output int first_c);
    logic [23:0] p;
    npulse  = 0;
    first_c = -1;
    for (int c = 0; c < len; c++) begin
      p = '0;
      if (c == t0) p[0] = 1'b1;
      if (c == t1) p[1] = 1'b1;
      if (c == t2) p[2] = 1'b1;
      trig_i = BASE ^ p;
      step();
      if (trig_o) begin
        npulse++;
        if (first_c < 0) first_c = c;
      end
    end
    trig_i = BASE;
  endtask

  task automatic setup_coinc(input logic [31:0] th);
    reg_write(4'd0, 32'h1);
    reg_write(4'd1, 32'h00FF_FFFF);
    reg_write(4'd2, 32'h8000_0000);
    reg_write(4'd3, 32'h00FF_FFFF);
    reg_write(4'd4, 32'h0000_2FFF);
    reg_write(4'd5, th);
  endtask

  initial begin
    trig_i       = BASE;
    bus.reg_wr   = 1'b0;
    bus.reg_rd   = 1'b0;
    bus.reg_addr = '0;
    bus.reg_wdat = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_trig_o", 32'(trig_o), 32'h0);
    check("reset_inhibit", 32'(inhibit_o), 32'h0);
    check("reset_rdat", bus.reg_rdat, 32'h0);
    rst_b = 1'b1;
    step();
    reg_read(4'd7, rd);
    check("reset_count", rd, 32'h0);

    // Soft trigger with everything disabled
    reg_write(4'd6, 32'h1);
    check("soft_not_yet", 32'(trig_o), 32'h0);
    step();
    check("soft_pulse", 32'(trig_o), 32'h1);
    check("soft_inhibit", 32'(inhibit_o), 32'h1);
    step();
    check("soft_one_cycle", 32'(trig_o), 32'h0);
    reg_read(4'd6, rd);
    check("overlord_read", rd, 32'h0001_0001);

    // Soft trigger while inhibited is dropped
    np = 0;
    reg_write(4'd6, 32'h1);
    repeat (4) begin
      step();
      if (trig_o) np++;
    end
    check("inhibited_no_pulse", 32'(np), 32'h0);
    reg_read(4'd7, rd);
    check("inhibited_count", rd, 32'h1);
    reg_write(4'd6, 32'h2);
    check("cpu_clear", 32'(inhibit_o), 32'h0);

    // Clear and soft together: clear first, pulse one cycle later
    reg_write(4'd6, 32'h1);
    step();
    check("soft2_pulse", 32'(trig_o), 32'h1);
    reg_write(4'd6, 32'h3);
    check("both_clear_first", 32'(inhibit_o), 32'h0);
    check("both_no_pulse_yet", 32'(trig_o), 32'h0);
    step();
    check("both_pulse", 32'(trig_o), 32'h1);
    check("both_inhibit", 32'(inhibit_o), 32'h1);
    reg_read(4'd7, rd);
    check("both_count", rd, 32'h3);
    reg_write(4'd6, 32'h2);

    // Configuration and register readback
    setup_coinc(32'h2);
    reg_read(4'd4, rd);
    check("window_read", rd, 32'h0000_2FFF);
    reg_read(4'd2, rd);
    check("trig_cfg_read", rd, 32'h8000_0000);
    reg_write(4'd9, 32'hFFFF_FFFF);
    reg_read(4'd9, rd);
    check("unlisted_read", rd, 32'h0);

    // Coincidence: three channels 10 clocks apart
    run3(0, 10, 20, 40, np, first);
    check("coinc_pulses", 32'(np), 32'h1);
    check("coinc_latency", 32'(first), 32'd22);
    reg_write(4'd6, 32'h2);

    // Window boundary: W=74, last channel at 73 is inside, at 74 outside
    run3(0, 40, 73, 80, np, first);
    check("win_edge_in", 32'(np), 32'h1);
    check("win_edge_in_at", 32'(first), 32'd75);
    reg_write(4'd6, 32'h2);
    run3(0, 40, 74, 170, np, first);
    check("win_edge_out", 32'(np), 32'h0);
    run3(0, -1, 80, 170, np, first);
    check("spaced_80", 32'(np), 32'h0);
    run3(0, 10, -1, 100, np, first);
    check("two_channels", 32'(np), 32'h0);

    reg_write(4'd2, 32'h0);
    run3(0, 10, 20, 110, np, first);
    check("coinc_disabled", 32'(np), 32'h0);
    reg_write(4'd2, 32'h8000_0000);
    reg_write(4'd1, 32'h00FF_FFFD);
    run3(0, 10, 20, 110, np, first);
    check("in_mask_bit1", 32'(np), 32'h0);
    reg_write(4'd1, 32'h00FF_FFFF);
    reg_read(4'd7, rd);
    check("count_after_coinc", rd, 32'h5);

    // Polarity: channel 0 held high is idle; a low pulse is an edge
    reg_write(4'd5, 32'h0);
    run3(-1, -1, -1, 20, np, first);
    check("pol_held_high", 32'(np), 32'h0);
    run3(5, -1, -1, 20, np, first);
    check("pol_pulse", 32'(np), 32'h1);
    check("pol_latency", 32'(first), 32'd7);
    reg_write(4'd6, 32'h2);

    // Coincidence and soft trigger in the same cycle
    trig_i = BASE ^ 24'h1;
    step();
    trig_i = BASE;
    reg_write(4'd6, 32'h1);
    check("simul_not_yet", 32'(trig_o), 32'h0);
    step();
    check("simul_pulse", 32'(trig_o), 32'h1);
    np = 0;
    repeat (5) begin
      step();
      if (trig_o) np++;
    end
    check("simul_single", 32'(np), 32'h0);
    reg_read(4'd7, rd);
    check("simul_count", rd, 32'h7);
    reg_write(4'd6, 32'h2);

    // Reset mid-inhibit
    reg_write(4'd6, 32'h1);
    step();
    check("pre_reset_inhibit", 32'(inhibit_o), 32'h1);
    rst_b = 1'b0;
    #1;
    check("rst_inhibit", 32'(inhibit_o), 32'h0);
    check("rst_trig_o", 32'(trig_o), 32'h0);
    step();
    rst_b = 1'b1;
    reg_read(4'd7, rd);
    check("rst_count", rd, 32'h0);
    reg_read(4'd1, rd);
    check("rst_in_mask", rd, 32'h0);

    // Reset mid-window: channels 0 and 1 active, then only channel 2 after reset
    setup_coinc(32'h2);
    run3(0, 5, -1, 10, np, first);
    reg_read(4'd4, rd);
    rst_b = 1'b0;
    #1;
    check("rst_rdat", bus.reg_rdat, 32'h0);
    step();
    rst_b = 1'b1;
    setup_coinc(32'h2);
    run3(-1, -1, 0, 20, np, first);
    check("rst_window_cleared", 32'(np), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
